// File: rtl/ctrl_demux2way.sv
// Steers one shared control level to one of two timer channels as a single-cycle
// event pulse plus a level-hold flag, with channel freeze while held and post-release lockout.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | armed; active_sel tracks sel, waiting for a rising edge on in
//   HELD  | event delivered; selection frozen, hold flag up until in falls
//   LOCK  | post-release lockout; rising edges ignored for HOLDOFF cycles
module ctrl_demux2way #(
  parameter int HOLDOFF = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic sel,
  output logic out1,
  output logic out2,
  output logic hold1,
  output logic hold2,
  output logic active_sel
);

  localparam int CW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (HOLDOFF > 0) ? CW'(HOLDOFF - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t        state, state_n;
  logic          in_q;
  logic [CW-1:0] cnt, cnt_n;
  logic          out1_n, out2_n, hold1_n, hold2_n, active_sel_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      // Start "high" so a level already asserted at reset release is not an edge.
      in_q       <= 1'b1;
      out1       <= 1'b0;
      out2       <= 1'b0;
      hold1      <= 1'b0;
      hold2      <= 1'b0;
      active_sel <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      in_q       <= in;
      out1       <= out1_n;
      out2       <= out2_n;
      hold1      <= hold1_n;
      hold2      <= hold2_n;
      active_sel <= active_sel_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    out1_n       = 1'b0;
    out2_n       = 1'b0;
    hold1_n      = hold1;
    hold2_n      = hold2;
    active_sel_n = active_sel;

    unique case (state)
      IDLE: begin
        active_sel_n = sel;
        if (in && !in_q) begin
          if (sel) begin
            out2_n  = 1'b1;
            hold2_n = 1'b1;
          end else begin
            out1_n  = 1'b1;
            hold1_n = 1'b1;
          end
          state_n = HELD;
        end
      end
      HELD: begin
        if (!in) begin
          hold1_n = 1'b0;
          hold2_n = 1'b0;
          if (HOLDOFF == 0) begin
            state_n = IDLE;
          end else begin
            cnt_n   = CNT_LOAD;
            state_n = LOCK;
          end
        end
      end
      LOCK: begin
        // Entered with HOLDOFF-1, so the lockout spans exactly HOLDOFF cycles.
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        hold1_n = 1'b0;
        hold2_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ctrl_demux2way.sv
// Directed bench for ctrl_demux2way (HOLDOFF=4): pulse/hold routing, selection
// freeze, post-release lockout, reset behaviour, and a per-cycle mutual-exclusion monitor.
module tb_ctrl_demux2way;

  logic clk = 1'b0;
  logic reset, in, sel;
  logic out1, out2, hold1, hold2, active_sel;

  int errors = 0;
  int checks = 0;

  ctrl_demux2way #(.HOLDOFF(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .sel        (sel),
    .out1       (out1),
    .out2       (out2),
    .hold1      (hold1),
    .hold2      (hold2),
    .active_sel (active_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Packed view {out1,out2,hold1,hold2,active_sel}
  function automatic logic [7:0] outs();
    return {3'b000, out1, out2, hold1, hold2, active_sel};
  endfunction

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if ((out1 & out2) || (hold1 & hold2)) $display("Incorrect Output!");
      chk("mutex", {6'd0, out1 & out2, hold1 & hold2}, 8'd0);
    end
  end

  initial begin
    reset = 1'b1; in = 1'b0; sel = 1'b0;
    step(2);
    chk("reset_state", outs(), 8'b00000);
    reset = 1'b0;

    // T1: channel 1 event
    step(8);
    in = 1'b1;
    step();
    chk("t1_pulse", outs(), 8'b10100);
    step();
    chk("t1_pulse_gone", outs(), 8'b00100);
    step();
    chk("t1_hold", outs(), 8'b00100);
    in = 1'b0;
    step();
    chk("t1_release", outs(), 8'b00000);
    step(5);

    // T2: channel 2 event, sel toggling while held is ignored
    sel = 1'b1;
    step();
    chk("t2_track_sel", outs(), 8'b00001);
    in = 1'b1;
    step();
    chk("t2_pulse", outs(), 8'b01011);
    sel = 1'b0;
    step();
    chk("t2_frozen_a", outs(), 8'b00011);
    sel = 1'b1;
    step();
    sel = 1'b0;
    step();
    chk("t2_frozen_b", outs(), 8'b00011);

    // T3: lockout after release; edges at +1 and +3 ignored, +6 accepted
    in = 1'b0;
    step();
    chk("t3_release", outs(), 8'b00001);
    in = 1'b1;
    step();
    chk("t3_lock_e1", outs(), 8'b00001);
    in = 1'b0;
    step();
    in = 1'b1;
    step();
    chk("t3_lock_e3", outs(), 8'b00001);
    in = 1'b0;
    step(2);
    chk("t3_idle_track", outs(), 8'b00000);
    in = 1'b1;
    step();
    chk("t3_pulse_e6", outs(), 8'b10100);
    in = 1'b0;
    step(6);

    // T4: in high across reset release, then a fresh edge gives one pulse
    in = 1'b1;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_no_pulse", outs(), 8'b00000);
    end
    in = 1'b0;
    step();
    in = 1'b1;
    step();
    chk("t4_pulse", outs(), 8'b10100);
    step();
    chk("t4_single", outs(), 8'b00100);
    in = 1'b0;
    step(6);

    // T5: sel change coincident with rising edge
    sel = 1'b1;
    in = 1'b1;
    step();
    chk("t5_same_cycle", outs(), 8'b01011);
    in = 1'b0;
    step(6);

    // T6: reset during HELD
    sel = 1'b0;
    step();
    in = 1'b1;
    step();
    chk("t6_pulse", outs(), 8'b10100);
    step();
    chk("t6_held", outs(), 8'b00100);
    reset = 1'b1;
    step();
    chk("t6_reset_clear", outs(), 8'b00000);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_stray", outs(), 8'b00000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
